// File: rtl/mux_4x1.sv
// mux_4x1 -- 4-to-1 channel multiplexer with enable and optional output register.
//
// Parameters
//   DW       width of each data channel and of y
//   OUT_REG  1 = y/y_valid registered (1-cycle latency), 0 = combinational bypass
//
// Ports
//   clk      rising-edge clock (used only when OUT_REG = 1)
//   rst      synchronous active-high reset (used only when OUT_REG = 1)
//   D        four packed channels, channel k at D[k*DW +: DW]
//   s        channel select, 2'b00..2'b11 -> ch0..ch3
//   en       active-high enable; disabled output is all-zero
//   y        selected channel value, or zero when disabled
//   y_valid  high when y carries a channel value sampled with en = 1
module mux_4x1 #(
    parameter int DW      = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4*DW-1:0] D,
    input  logic [1:0]      s,
    input  logic            en,
    output logic [DW-1:0]   y,
    output logic            y_valid
);

    logic [DW-1:0] sel_s;

    // Next-value selection: one channel when enabled, zero otherwise.
    always_comb begin
        sel_s = {DW{1'b0}};
        if (en) begin
            case (s)
                2'b00:   sel_s = D[0*DW +: DW];
                2'b01:   sel_s = D[1*DW +: DW];
                2'b10:   sel_s = D[2*DW +: DW];
                2'b11:   sel_s = D[3*DW +: DW];
                default: sel_s = {DW{1'b0}};
            endcase
        end else begin
            sel_s = {DW{1'b0}};
        end
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [DW-1:0] y_r;
            logic          y_valid_r;

            // Output register; reset overrides any enable/select/data on the same edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    y_r       <= {DW{1'b0}};
                    y_valid_r <= 1'b0;
                end else begin
                    y_r       <= sel_s;
                    y_valid_r <= en;
                end
            end

            assign y       = y_r;
            assign y_valid = y_valid_r;
        end else begin : g_comb
            // Clock and reset have no role in bypass mode.
            logic unused_s;
            assign unused_s = clk ^ rst;

            assign y       = sel_s;
            assign y_valid = en;
        end
    endgenerate

endmodule

// File: tb/tb_mux_4x1.sv
module tb_mux_4x1;

    logic        clk;
    logic        rst;
    logic [3:0]  D;
    logic [1:0]  s;
    logic        en;
    logic [0:0]  y;
    logic        y_valid;

    logic        rst_b;
    logic [15:0] d_b;
    logic [1:0]  s_b;
    logic        en_b;
    logic [3:0]  y_b;
    logic        y_valid_b;

    int vectors;
    int miscompares;

    mux_4x1 #(.DW(1), .OUT_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .D(D), .s(s), .en(en), .y(y), .y_valid(y_valid)
    );

    mux_4x1 #(.DW(4), .OUT_REG(1'b0)) dut_byp (
        .clk(clk), .rst(rst_b), .D(d_b), .s(s_b), .en(en_b), .y(y_b), .y_valid(y_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; D = 4'b1111; s = 2'b00;
        step();
        vectors++;
        if (y !== 1'b0 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: y=%b y_valid=%b, expected y=0 y_valid=0", y, y_valid);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (y !== 1'b1 || y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: y=%b y_valid=%b, expected y=1 y_valid=1", y, y_valid);
        end
    endtask

    task automatic test_sweep(input logic [3:0] data, input logic [3:0] exp);
        D = data; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s = k[1:0];
            step();
            vectors++;
            if (y !== exp[k] || y_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL sweep D=%b s=%0d: y=%b y_valid=%b, expected y=%b y_valid=1",
                         data, k, y, y_valid, exp[k]);
            end
        end
    endtask

    task automatic test_disable();
        D = 4'b1111; s = 2'b10; en = 1'b0;
        step();
        vectors++;
        if (y !== 1'b0 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL disable: y=%b y_valid=%b, expected y=0 y_valid=0", y, y_valid);
        end
        en = 1'b1;
        step();
        vectors++;
        if (y !== 1'b1 || y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reenable: y=%b y_valid=%b, expected y=1 y_valid=1", y, y_valid);
        end
    endtask

    task automatic test_reset_mid();
        D = 4'b1111; s = 2'b11; en = 1'b1;
        step();
        vectors++;
        if (y !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: y=%b, expected 1", y);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (y !== 1'b0 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: y=%b y_valid=%b, expected y=0 y_valid=0", y, y_valid);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (y !== 1'b1 || y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_release: y=%b y_valid=%b, expected y=1 y_valid=1", y, y_valid);
        end
    endtask

    task automatic test_tracking();
        logic b;
        logic prev;
        s = 2'b01; en = 1'b1; D = 4'b1101;
        step();
        prev = 1'b0;
        b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            // Other channels always carry the opposite value of ch1.
            D = b ? 4'b0010 : 4'b1101;
            #1;
            vectors++;
            if (y !== prev) begin
                miscompares++;
                $display("FAIL track_hold i=%0d: y=%b, expected %b", i, y, prev);
            end
            step();
            vectors++;
            if (y !== b || y_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL track i=%0d: y=%b y_valid=%b, expected y=%b y_valid=1",
                         i, y, y_valid, b);
            end
            prev = b;
            b = ~b;
        end
    endtask

    task automatic test_simultaneous();
        // s, D, en all change for the same edge.
        D = 4'b0100; s = 2'b10; en = 1'b1;
        step();
        D = 4'b1000; s = 2'b01; en = 1'b0;
        step();
        vectors++;
        if (y !== 1'b0 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_off: y=%b y_valid=%b, expected y=0 y_valid=0", y, y_valid);
        end
        D = 4'b1000; s = 2'b11; en = 1'b1;
        step();
        vectors++;
        if (y !== 1'b1 || y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_on: y=%b y_valid=%b, expected y=1 y_valid=1", y, y_valid);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_nib;
        exp_nib = 16'hA5C3;
        rst_b = 1'b0; d_b = 16'hA5C3; en_b = 1'b1; s_b = 2'b10;
        #1;
        vectors++;
        if (y_b !== 4'h5 || y_valid_b !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_s2: y=%h y_valid=%b, expected y=5 y_valid=1", y_b, y_valid_b);
        end
        for (int k = 0; k < 4; k++) begin
            s_b = k[1:0];
            #1;
            vectors++;
            if (y_b !== exp_nib[k*4 +: 4]) begin
                miscompares++;
                $display("FAIL bypass_sweep s=%0d: y=%h, expected %h", k, y_b, exp_nib[k*4 +: 4]);
            end
        end
        en_b = 1'b0;
        #1;
        vectors++;
        if (y_b !== 4'h0 || y_valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_off: y=%h y_valid=%b, expected y=0 y_valid=0", y_b, y_valid_b);
        end
        // Reset across a clock edge must not touch bypass outputs.
        en_b = 1'b1; s_b = 2'b01; rst_b = 1'b1;
        step();
        vectors++;
        if (y_b !== 4'hC || y_valid_b !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_rst: y=%h y_valid=%b, expected y=c y_valid=1", y_b, y_valid_b);
        end
        rst_b = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; D = 4'b0000; s = 2'b00; en = 1'b0;
        rst_b = 1'b0; d_b = 16'h0000; s_b = 2'b00; en_b = 1'b0;

        test_reset();
        test_sweep(4'b0110, 4'b0110);
        test_sweep(4'b1001, 4'b1001);
        test_disable();
        test_reset_mid();
        test_tracking();
        test_simultaneous();
        test_bypass();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_4x1.md
MUX_4X1 -- requirements
Module: mux_4x1

Interface
REQ-001 Parameter: DW, default 1, bit width of each data channel and of y.
REQ-002 Parameter: OUT_REG, default 1; 1 = registered output, 0 = combinational output (bypass mode).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: D  input  4*DW  four data channels; channel k occupies D[k*DW +: DW].
REQ-006 Port: s  input  2  channel select; 00=ch0, 01=ch1, 10=ch2, 11=ch3.
REQ-007 Port: en  input  1  enable; active-high.
REQ-008 Port: y  output  DW  selected channel, or all-zero when disabled.
REQ-009 Port: y_valid  output  1  high when y carries a channel value sampled with en=1.

Function
REQ-010 The block SHALL compute a next value sel = D[s*DW +: DW] when en=1, and sel = 0 when en=0.
REQ-011 With OUT_REG=1, the block SHALL register sel into y on each rising clk edge (latency exactly 1 cycle).
REQ-012 With OUT_REG=1, the block SHALL register en into y_valid on the same edge.
REQ-013 With OUT_REG=0, the block SHALL drive y = sel and y_valid = en combinationally, with zero latency; rst SHALL have no effect on the outputs.
REQ-014 The block SHALL never pass a non-selected channel to y, including on the cycle s changes.
REQ-015 The block SHALL follow changes to D on the selected channel every cycle while en=1; there is no hold or latch of D.
REQ-016 When en falls, y SHALL go to 0 and y_valid to 0 one cycle later (OUT_REG=1) or immediately (OUT_REG=0).
REQ-017 Simultaneous changes of s, D and en SHALL be resolved using the values sampled at the same clk edge.
REQ-018 The block SHALL decode all four s values; no select value is illegal.

Reset
REQ-019 With OUT_REG=1, rst=1 at a rising clk edge SHALL force y=0 and y_valid=0, overriding en, s and D.
REQ-020 Reset SHALL have priority over a simultaneous en=1 on the same edge.
REQ-021 On the first edge with rst=0, the block SHALL resume normal sampling; no extra recovery cycles.
REQ-022 Asserting reset mid-operation SHALL clear the outputs on the next edge with no residual state.

Verification
REQ-023 Select sweep, D=4'b0110, en=1: s=00,01,10,11 -> y=0,1,1,0 one cycle after each, y_valid=1.
REQ-024 Select sweep, D=4'b1001, en=1: s=00,01,10,11 -> y=1,0,0,1, y_valid=1.
REQ-025 Disable: D=4'b1111, s=10, en=0 -> y=0, y_valid=0 next cycle; en back to 1 -> y=1 next cycle.
REQ-026 Reset mid-stream: D=4'b1111, en=1, y=1; assert rst one cycle -> y=0, y_valid=0 at that edge; release -> y=1 next edge.
REQ-027 Data tracking: s=01, en=1, toggle D[1] every cycle -> y follows D[1] with 1-cycle delay, no glitch from other channels.
REQ-028 Bypass mode: OUT_REG=0, DW=4, D=16'hA5C3, en=1, s=10 -> y=4'h5 in the same cycle; en=0 -> y=0 immediately.
